// File: rtl/undertale_pkg.sv
// Shared constants and colour helpers for the sprite pipeline: sprite box size,
// RGB332 field layout, transparent key and RGB332 -> RGB444 expansion.
package undertale_pkg;

    localparam int unsigned    SPRITE_W_DEFAULT    = 31;
    localparam int unsigned    SPRITE_H_DEFAULT    = 30;
    localparam logic [7:0]     TRANSPARENT_DEFAULT = 8'hE3;

    localparam int unsigned    RGB332_R_LSB = 5;
    localparam int unsigned    RGB332_G_LSB = 2;
    localparam int unsigned    RGB332_B_LSB = 0;

    // Replicating the top bits spreads 3/2-bit fields evenly over 4 bits (7 -> F, 3 -> F).
    function automatic logic [11:0] rgb332_to_rgb444(input logic [7:0] c);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = c[RGB332_R_LSB +: 3];
        g = c[RGB332_G_LSB +: 3];
        b = c[RGB332_B_LSB +: 2];
        return {r, r[2], g, g[2], b, b};
    endfunction

endpackage

// File: rtl/monster_flash_ctrl.sv
// Damage-blink frame counter: counts frame ticks while flash is held and
// blanks the sprite during the upper half of each 16-frame cycle.
module monster_flash_ctrl (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_tick,
    input  logic flash,
    output logic blank
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!flash) begin
            r_cnt <= '0;
        end else if (frame_tick) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign blank = flash & r_cnt[3];

endmodule

// File: rtl/monster_sprite_renderer.sv
// Three-stage monster sprite pipeline: box test and ROM address, ROM latency
// alignment, colour key and RGB444 output. Blink support under MONSTER_FLASH_EN.
module monster_sprite_renderer
    import undertale_pkg::*;
#(
    parameter int unsigned SPRITE_W    = SPRITE_W_DEFAULT,
    parameter int unsigned SPRITE_H    = SPRITE_H_DEFAULT,
    parameter logic [7:0]  TRANSPARENT = TRANSPARENT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        flash,
    output logic [9:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic [11:0] pixel_rgb,
    output logic        pixel_hit
);

    localparam logic [10:0] W11 = 11'(SPRITE_W);
    localparam logic [10:0] H11 = 11'(SPRITE_H);

    logic [9:0]  r_px;
    logic [9:0]  r_py;
    logic        r_in_box_d1;
    logic        r_in_box_d2;

    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [10:0] w_col;
    logic [10:0] w_row;
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic        w_in_box;
    logic [9:0]  w_addr;
    logic        w_blank;
    logic        w_hit;

    // 11-bit arithmetic: an overhanging sprite clips at the screen edge instead of wrapping.
    assign w_x      = {1'b0, x};
    assign w_y      = {1'b0, y};
    assign w_col    = w_x - {1'b0, r_px};
    assign w_row    = w_y - {1'b0, r_py};
    assign w_x_end  = {1'b0, r_px} + W11;
    assign w_y_end  = {1'b0, r_py} + H11;
    assign w_in_box = video_on
                    & (w_x >= {1'b0, r_px}) & (w_x < w_x_end)
                    & (w_y >= {1'b0, r_py}) & (w_y < w_y_end);
    // row*31 + col without a multiplier
    assign w_addr   = 10'((w_row << 5) - w_row + w_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_px <= '0;
            r_py <= '0;
        end else if (frame_tick) begin
            r_px <= pos_x;
            r_py <= pos_y;
        end
    end

`ifdef MONSTER_FLASH_EN
    monster_flash_ctrl u_flash_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .flash      (flash),
        .blank      (w_blank)
    );
`else
    logic w_flash_unused;
    assign w_flash_unused = flash;
    assign w_blank        = 1'b0;
`endif

    assign w_hit = r_in_box_d2 & (rom_data != TRANSPARENT) & ~w_blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr    <= '0;
            r_in_box_d1 <= 1'b0;
            r_in_box_d2 <= 1'b0;
            pixel_hit   <= 1'b0;
            pixel_rgb   <= '0;
        end else begin
            rom_addr    <= w_in_box ? w_addr : '0;
            r_in_box_d1 <= w_in_box;
            r_in_box_d2 <= r_in_box_d1;
            pixel_hit   <= w_hit;
            pixel_rgb   <= w_hit ? rgb332_to_rgb444(rom_data) : '0;
        end
    end

endmodule

// File: doc/monster_sprite_renderer.md
# monster_sprite_renderer

Pixel-pipeline stage between the VGA timing generator and the monster sprite ROM. Per pixel it decides whether the current screen coordinate falls inside the 31×30 monster box and computes the ROM word address. It then takes the ROM's registered byte one cycle later, keys out the transparent colour, and presents a 12-bit Basys3 RGB value with a hit flag to the screen compositor. The on-screen position is latched once per frame so the sprite never tears mid-frame.

## Interface
- SPRITE_W, 31: sprite width in pixels.
- SPRITE_H, 30: sprite height in pixels.
- TRANSPARENT, 8'hE3: RGB332 colour key treated as see-through.
- clk  in  1  pixel clock (25 MHz)
- rst_n  in  1  asynchronous, active-low reset
- x  in  10  current pixel column (0–639)
- y  in  10  current pixel row (0–479)
- video_on  in  1  high during the visible area
- frame_tick  in  1  one-cycle pulse at the start of vertical blanking
- pos_x  in  10  requested sprite left edge
- pos_y  in  10  requested sprite top edge
- flash  in  1  damage-blink request (see Configuration)
- rom_addr  out  10  word address to the sprite ROM
- rom_data  in  8  RGB332 byte from the ROM, valid one cycle after rom_addr
- pixel_rgb  out  12  {R4,G4,B4} sprite colour, 0 when pixel_hit is low
- pixel_hit  out  1  sprite pixel present and opaque

## Operation
- Position latch: on frame_tick, load pos_x/pos_y into px_q/py_q. The latched values are used from the next cycle. Reset value is 0/0.
- Stage 1 (registered): compute col = x − px_q and row = y − py_q in 11 bits. Set in_box = video_on & (x ≥ px_q) & (x < px_q+SPRITE_W) & (y ≥ py_q) & (y < py_q+SPRITE_H). All sums are 11-bit, so a sprite that overhangs the right or bottom edge clips and never wraps.
- rom_addr = (row<<5) − row + col when in_box, otherwise 0. The range is 0–929. No multiplier is used.
- Stage 2: in_box is delayed one cycle to match ROM latency.
- Stage 3 (registered output):
  - pixel_hit = in_box_d2 & (rom_data ≠ TRANSPARENT) & ~blank.
  - pixel_rgb = {r,r[2]} , {g,g[2]} , {b,b} when the hit is set, otherwise 12'h000.
- A frame_tick that coincides with an active pixel is legal. The pixel in that same cycle uses the old position.
- Reset mid-frame clears every pipeline register and the position latch. Output reappears after 3 cycles of valid input.

## Timing
- Latency: x/y/video_on at cycle n → rom_addr at n+1 → rom_data at n+2 → pixel_rgb/pixel_hit at n+3. This holds for every pixel, with no bubbles.
- Throughput is one pixel per clk. There is no stall or handshake. The compositor delays its own inputs by 3 cycles.
- Reset values:
  - rom_addr = 0.
  - pixel_rgb = 12'h000.
  - pixel_hit = 0.
  - All pipeline flags are 0.

## Configuration
- MONSTER_FLASH_EN defined: a 4-bit frame counter increments on each frame_tick while flash=1. It clears to 0 the cycle flash is sampled low, and wraps 15→0. blank = flash & cnt[3], so the sprite is hidden for 8 frames, shown for 8, and repeats.
- MONSTER_FLASH_EN undefined: the counter is not built, blank = 0, and the flash port is ignored.

## Structure
- Shared package undertale_pkg holds:
  - SPRITE_W and SPRITE_H defaults.
  - the RGB332 field positions.
  - the rgb332_to_rgb444 function.
  - the TRANSPARENT default constant.
- One sub-module, monster_flash_ctrl, holds the frame counter and blank output. It is instantiated only under MONSTER_FLASH_EN.
- The ROM is external. This block drives rom_addr and consumes rom_data only.

## Test plan
- Corners: with pos 100/50, drive x=100,y=50 → rom_addr=0 at n+1, then x=130,y=79 → rom_addr=929. Pixel x=131 gives pixel_hit=0 at n+3.
- Colour and transparency: ROM returns 8'hE3 → pixel_hit=0, rgb=000. ROM returns 8'hFF → rgb=FFF, hit=1. ROM returns 8'h1C → rgb=0F0.
- Clipping: pos_x=620, x=639 → addr=19, hit follows data. x=0 on the same row → no hit (no wrap).
- Latch: change pos_x mid-frame without frame_tick → no effect. After frame_tick, the next pixel uses the new position.
- Reset: assert rst_n=0 while hit=1 → pixel_hit, pixel_rgb and rom_addr are 0 immediately. Released, the first hit appears 3 cycles after a valid in-box pixel.
- Flash (with MONSTER_FLASH_EN): flash=1 for 16 frame_ticks → hit suppressed in frames 8–15. With flash=0 the counter returns to 0 and the sprite is always visible.
